fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage; the writer side of the IF/ID pipeline latch.
- Owns the PC and drives the instruction-memory request (ren/addr, completed by ihit).
- Presents instr/npc plus enable and flush to the IF/ID latch.
- Absorbs decode stalls with a one-entry skid buffer; applies branch/jump redirects from later stages and halts on request.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- imem_ren  out  1  instruction read request
- imem_addr  out  32  fetch address (word-aligned)
- imem_load  in  32  instruction data, valid when ihit=1
- ihit  in  1  instruction memory completes request this cycle
- stall  in  1  IF/ID latch may not load this cycle (hazard unit)
- redirect  in  1  taken branch/jump; discard wrong-path work
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 00)
- halt  in  1  halt instruction decoded; stop fetching
- instr_o  out  32  instruction to IF/ID latch
- npc_o  out  32  address of instruction + PC_STEP to IF/ID latch
- en_o  out  1  IF/ID latch load enable
- flush_o  out  1  IF/ID latch clear

Behaviour:
- Reset (RST high at edge): pc=PC_INIT, state=FETCH, skid buffer cleared (buf_instr=0, buf_npc=0).
- Output values during and immediately after reset: imem_ren=1, imem_addr=PC_INIT, en_o=0 unless ihit, flush_o=0, instr_o=imem_load, npc_o=PC_INIT+PC_STEP.
- RST overrides every other input, including mid-request and in HOLD/HALTED.
- States:
  - FETCH: request in flight.
  - HOLD: instruction buffered, waiting for stall to drop.
  - HALTED: terminal until reset.
- FETCH outputs: imem_ren=1, imem_addr=pc, instr_o=imem_load, npc_o=pc+PC_STEP.
  - ihit & !stall: en_o=1 (combinational, same cycle), pc<=pc+PC_STEP, stay FETCH.
  - ihit & stall: en_o=0, buf_instr<=imem_load, buf_npc<=pc+PC_STEP, pc<=pc+PC_STEP, go to HOLD.
  - !ihit: en_o=0, pc unchanged, address held stable.
- HOLD outputs: imem_ren=0, instr_o=buf_instr, npc_o=buf_npc, en_o=!stall.
  - !stall: go to FETCH next cycle. Latency is one cycle from stall release to the next request.
- HALTED outputs: imem_ren=0, en_o=0, flush_o=0. pc frozen. redirect and halt are ignored.
- Redirect (FETCH or HOLD), highest priority after RST:
  - flush_o=1 and en_o=0 in the same cycle.
  - pc<={redirect_pc[31:2],2'b00}; skid buffer invalidated; state<=FETCH.
  - A coincident ihit's data is dropped; pc does not advance past the redirect target.
- Halt (FETCH or HOLD, redirect=0): state<=HALTED next cycle.
  - A coincident ihit & !stall still loads that instruction (en_o=1).
  - redirect & halt in the same cycle: redirect wins and halt is discarded (wrong-path halt).
- Arithmetic: pc+PC_STEP is modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Invariants:
  - en_o and flush_o are never both 1.
  - imem_ren=0 whenever state != FETCH.
  - imem_addr[1:0] is always 00.

Decomposition:
- Shared CPU types package holds: word_t (32-bit), fetch_state_t enum {FETCH, HOLD, HALTED}, PC_INIT_DEFAULT constant.
- One natural sub-module: fetch_skid_buf. It is a one-entry instr/npc register with capture, release, and invalidate controls, plus a valid bit.
- PC register and state machine stay in fetch_unit.

Test Plan:
- Reset, then ihit=1 every cycle, stall=0 -> imem_addr 0,4,8; en_o=1 each cycle; npc_o 4,8,12; instr_o follows imem_load.
- ihit=1 with stall=1 at pc=0x10, load=0xDEADBEEF -> next cycles: state HOLD, imem_ren=0, instr_o=0xDEADBEEF, npc_o=0x14, en_o=0. Drop stall -> en_o=1 for one cycle; following cycle imem_addr=0x14.
- In HOLD, assert redirect=1, redirect_pc=0x103 -> flush_o=1, en_o=0 that cycle. Next cycle: imem_addr=0x100, imem_ren=1, buffer discarded.
- redirect=1 and halt=1 together at pc=0x20, target 0x40 -> not halted; imem_addr=0x40 next cycle. Later halt=1 alone -> imem_ren=0 and en_o=0 permanently; redirect ignored; RST restores imem_addr=PC_INIT.
- pc=0xFFFF_FFFC, ihit=1, stall=0 -> npc_o=0x0, next imem_addr=0x0.
- RST asserted while ihit=0 mid-request at pc=0x80 -> next cycle imem_addr=PC_INIT, state FETCH, en_o=0, flush_o=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared CPU fetch types, reset PC and address alignment helper
package fetch_unit_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FETCH, HOLD, HALTED} fetch_state_t;
  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;
  function automatic word_t align_word(input word_t a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_skid_buf.sv
// fetch_unit_skid_buf: one-entry instr/npc holding register for stalled fetches
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  capture_i,
  input  logic  release_i,
  input  logic  invalidate_i,
  input  word_t instr_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t npc_o,
  output logic  valid_o
);
  word_t instr_q, npc_q;
  logic  valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (capture_i) begin
      instr_q <= instr_i;
      npc_q   <= npc_i;
      valid_q <= 1'b1;
    end else if (invalidate_i || release_i) begin
      valid_q <= 1'b0;
    end
  end
  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction-memory request and IF/ID latch control with skid buffer
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t PC_INIT = PC_INIT_DEFAULT,
  parameter int    PC_STEP = 4
) (
  input  logic  CLK,
  input  logic  RST,
  output logic  imem_ren,
  output word_t imem_addr,
  input  word_t imem_load,
  input  logic  ihit,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output word_t instr_o,
  output word_t npc_o,
  output logic  en_o,
  output logic  flush_o
);
  fetch_state_t state_q, st;
  word_t pc_q, pc_v, pc_inc, buf_instr, buf_npc;
  logic in_fetch, in_hold, active, redir, cap, rel, buf_valid;
  // reset forces the visible state so outputs are already the post-reset values
  assign st       = RST ? FETCH : state_q;
  assign pc_v     = RST ? PC_INIT : pc_q;
  assign pc_inc   = pc_v + word_t'(PC_STEP);
  assign in_fetch = st == FETCH;
  assign in_hold  = st == HOLD;
  assign active   = st != HALTED;
  assign redir    = !RST && active && redirect;
  assign cap      = !RST && in_fetch && ihit && stall && !redirect && !halt;
  assign rel      = in_hold && !stall;
  assign imem_ren  = in_fetch;
  assign imem_addr = pc_v;
  assign instr_o   = (in_hold && buf_valid) ? buf_instr : imem_load;
  assign npc_o     = (in_hold && buf_valid) ? buf_npc : pc_inc;
  assign en_o      = !redir && (in_fetch ? ihit && !stall : rel);
  assign flush_o   = redir;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else if (redir) begin
      state_q <= FETCH;
      pc_q    <= align_word(redirect_pc);
    end else if (active) begin
      if (in_fetch && ihit) pc_q <= pc_inc;
      state_q <= halt ? HALTED : cap ? HOLD : rel ? FETCH : state_q;
    end
  end
  fetch_skid_buf u_skid (
    .clk         (CLK),
    .rst         (RST),
    .capture_i   (cap),
    .release_i   (rel),
    .invalidate_i(redir),
    .instr_i     (imem_load),
    .npc_i       (pc_inc),
    .instr_o     (buf_instr),
    .npc_o       (buf_npc),
    .valid_o     (buf_valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random stimulus against a behavioural fetch model
module tb_fetch_unit;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  logic CLK = 1'b0, RST, ihit, stall, redirect, halt;
  logic [31:0] imem_load, redirect_pc, imem_addr, instr_o, npc_o;
  logic imem_ren, en_o, flush_o;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_bi, m_bn;
  bit m_hold, m_halt;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_load(imem_load), .ihit(ihit), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .instr_o(instr_o), .npc_o(npc_o),
    .en_o(en_o), .flush_o(flush_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit ih, input bit st, input bit rd,
                     input logic [31:0] rp, input bit hl, input logic [31:0] ld);
    logic [31:0] e_addr;
    bit e_ren, e_en, e_fl, fetching;
    RST = r; ihit = ih; stall = st; redirect = rd; redirect_pc = rp; halt = hl; imem_load = ld;
    #2;
    fetching = r || (!m_halt && !m_hold);
    e_ren  = fetching;
    e_addr = r ? PC_INIT : m_pc;
    e_fl   = !r && !m_halt && rd;
    e_en   = r ? (ih && !st) : (m_halt || rd) ? 1'b0 : m_hold ? !st : (ih && !st);
    chk("imem_ren", {31'd0, imem_ren}, {31'd0, e_ren});
    chk("flush_o", {31'd0, flush_o}, {31'd0, e_fl});
    chk("en_o", {31'd0, en_o}, {31'd0, e_en});
    if (e_ren) begin
      chk("imem_addr", imem_addr, e_addr);
      chk("instr_o", instr_o, ld);
      chk("npc_o", npc_o, e_addr + 32'd4);
    end else if (!r && m_hold && !m_halt) begin
      chk("hold_instr", instr_o, m_bi);
      chk("hold_npc", npc_o, m_bn);
    end
    @(posedge CLK);
    if (r) begin
      m_pc = PC_INIT; m_hold = 0; m_halt = 0; m_bi = 0; m_bn = 0;
    end else if (!m_halt) begin
      if (rd) begin
        m_pc = rp & ~32'd3; m_hold = 0;
      end else begin
        if (!m_hold && ih) begin
          if (st) begin m_hold = 1; m_bi = ld; m_bn = m_pc + 32'd4; end
          m_pc = m_pc + 32'd4;
        end else if (m_hold && !st) m_hold = 0;
        if (hl) m_halt = 1;
      end
    end
    #1;
  endtask

  initial begin
    m_pc = 0; m_bi = 0; m_bn = 0; m_hold = 0; m_halt = 0;
    RST = 1; ihit = 0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0; imem_load = 0;
    #1;
    cyc(1, 0, 0, 0, 0, 0, 32'h1111_1111);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 32'hA000_0000 + i);
    cyc(0, 1, 1, 0, 0, 0, 32'hDEAD_BEEF);
    cyc(0, 0, 1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 1, 1, 0, 0, 0, 32'h1234_5678);
    cyc(0, 0, 1, 1, 32'h0000_0103, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0000_0020, 0, 32'h0);
    cyc(0, 1, 0, 1, 32'h0000_0040, 1, 32'h5555_5555);
    cyc(0, 1, 0, 0, 0, 0, 32'h6666_6666);
    cyc(0, 1, 0, 0, 0, 1, 32'h7777_7777);
    cyc(0, 1, 0, 1, 32'h0000_0300, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 32'h8888_8888);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0000_0080, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 2, $urandom_range(99) < 60, $urandom_range(99) < 35,
          $urandom_range(99) < 8, $urandom, $urandom_range(199) < 3, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
